// File: rtl/text_ram_writer_pkg.sv
// Shared definitions for the VGA text write path: default geometry, field
// widths, the ASCII codes the writer interprets, and the writer FSM state type.
package vga_text_pkg;

  localparam int DEF_COLS  = 41;
  localparam int DEF_ROWS  = 8;
  localparam int DEF_DEPTH = DEF_COLS * DEF_ROWS;

  localparam int ROW_W  = 3;
  localparam int COL_W  = 6;
  localparam int ADDR_W = 9;
  localparam int CHAR_W = 8;

  localparam logic [CHAR_W-1:0] SPACE     = 8'h20;
  localparam logic [CHAR_W-1:0] BS        = 8'h08;
  localparam logic [CHAR_W-1:0] LF        = 8'h0A;
  localparam logic [CHAR_W-1:0] CR        = 8'h0D;
  localparam logic [CHAR_W-1:0] FF        = 8'h0C;
  localparam logic [CHAR_W-1:0] PRINT_MIN = 8'h20;
  localparam logic [CHAR_W-1:0] PRINT_MAX = 8'h7E;

  typedef enum logic {
    CLEAR,
    IDLE
  } wr_state_t;

endpackage

// File: rtl/text_ram_writer_if.sv
// Character stream handshake into the text writer.
//   in_valid : source has a character on in_char
//   in_char  : ASCII code, held stable until accepted
//   in_ready : writer accepts in_char this cycle
interface text_ram_writer_if;
  import vga_text_pkg::*;

  logic              in_valid;
  logic [CHAR_W-1:0] in_char;
  logic              in_ready;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);

endinterface

// File: rtl/text_ram_writer_cursor.sv
// Cursor row/column counter for the text array.
//   clk, rst     : clock, synchronous active-high reset to (0,0)
//   advance_i    : step right, wrapping to next row and from the last cell to (0,0)
//   back_i       : step left, wrapping to previous row's last column; holds at (0,0)
//   newline_i    : go to column 0 of the next row, last row wraps to row 0
//   home_col_i   : go to column 0 of the current row
//   home_i       : go to (0,0)
//   row_o, col_o : current position
//   addr_o       : row_o*COLS + col_o
// Commands are expected one-hot; home_i wins if several are raised.
module text_cursor
  import vga_text_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance_i,
  input  logic              back_i,
  input  logic              newline_i,
  input  logic              home_col_i,
  input  logic              home_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             at_last_row;

  assign at_last_row = (row_q == LAST_ROW);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (home_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (back_i) begin
      if (col_q != '0) begin
        col_d = col_q - COL_W'(1);
      end else if (row_q != '0) begin
        row_d = row_q - ROW_W'(1);
        col_d = LAST_COL;
      end
    end else if (newline_i) begin
      col_d = '0;
      row_d = at_last_row ? '0 : row_q + ROW_W'(1);
    end else if (home_col_i) begin
      col_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

endmodule

// File: rtl/text_ram_writer.sv
// Write side of the VGA text display. Consumes ASCII characters, keeps the
// cursor, handles BS/LF/CR/FF and clears the character array with 0x20.
//   clk, rst    : system clock, synchronous active-high reset (starts a clear)
//   in_if       : character handshake (in_valid, in_char, in_ready)
//   busy        : clear sweep in progress
//   cursor_row  : current row
//   cursor_col  : current column
//   cursor_addr : cursor_row*COLS + cursor_col
//   ram         : character array, ASCII in [7:0], upper bits zero
module text_ram_writer
  import vga_text_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int DEPTH = COLS * ROWS
) (
  input  logic               clk,
  input  logic               rst,
  text_ram_writer_if.slave   in_if,
  output logic               busy,
  output logic [ROW_W-1:0]   cursor_row,
  output logic [COL_W-1:0]   cursor_col,
  output logic [ADDR_W-1:0]  cursor_addr,
  output logic [31:0]        ram [DEPTH-1:0]
);

  wr_state_t         state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              in_ready_q;
  logic              busy_q;

  logic [CHAR_W-1:0] ch;
  logic              accept;
  logic              is_print, is_bs, is_lf, is_cr, is_ff;
  logic              cmd_adv, cmd_back, cmd_nl, cmd_home_col, cmd_home;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [CHAR_W-1:0] wdata;
  logic [CHAR_W-1:0] mem_q [DEPTH];

  assign ch     = in_if.in_char;
  // Reset wins over a pending accept in the same cycle.
  assign accept = in_if.in_valid && in_ready_q && !rst;

  assign is_print = (ch >= PRINT_MIN) && (ch <= PRINT_MAX);
  assign is_bs    = (ch == BS);
  assign is_lf    = (ch == LF);
  assign is_cr    = (ch == CR);
  assign is_ff    = (ch == FF);

  assign cmd_adv      = accept && is_print;
  assign cmd_back     = accept && is_bs && (cursor_addr != '0);
  assign cmd_nl       = accept && is_lf;
  assign cmd_home_col = accept && is_cr;
  assign cmd_home     = accept && is_ff;

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .advance_i  (cmd_adv),
    .back_i     (cmd_back),
    .newline_i  (cmd_nl),
    .home_col_i (cmd_home_col),
    .home_i     (cmd_home),
    .row_o      (cursor_row),
    .col_o      (cursor_col),
    .addr_o     (cursor_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (cmd_home) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= CLEAR;
          clr_addr_q <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  // Single write port: sweep, printable store and backspace erase are
  // mutually exclusive because the sweep only runs while in_ready is low.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!rst) begin
      if (state_q == CLEAR) begin
        we    = 1'b1;
        waddr = clr_addr_q;
        wdata = SPACE;
      end else if (cmd_adv) begin
        we    = 1'b1;
        waddr = cursor_addr;
        wdata = ch;
      end else if (cmd_back) begin
        we    = 1'b1;
        waddr = cursor_addr - ADDR_W'(1);
        wdata = SPACE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ram
    assign ram[g] = {{(32 - CHAR_W){1'b0}}, mem_q[g]};
  end

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_text_ram_writer.sv
// Scoreboard bench for text_ram_writer: the stimulus thread pushes the
// expected word and cursor for every character it offers; a monitor pops one
// entry per accepted character and compares one cycle after the accept.
module tb_text_ram_writer;

  localparam int COLS  = 41;
  localparam int ROWS  = 8;
  localparam int DEPTH = 328;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [2:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic [8:0]  cursor_addr;
  logic [31:0] ram [DEPTH-1:0];

  text_ram_writer_if tif ();

  text_ram_writer #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (tif),
    .busy        (busy),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .cursor_addr (cursor_addr),
    .ram         (ram)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          has_word;
    int          widx;
    logic [31:0] wval;
    int          row;
    int          col;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cur   = 0;
  logic acc_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input string n, input bit hw, input int wi,
                              input logic [31:0] wv, input int a);
    exp_t e;
    e.name = n; e.has_word = hw; e.widx = wi; e.wval = wv;
    e.row = a / COLS; e.col = a % COLS;
    return e;
  endfunction

  // Accept as seen by the DUT at this edge (reset suppresses it).
  always @(posedge clk) acc_seen <= tif.in_valid && tif.in_ready && !rst;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (acc_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_row"}, 32'(cursor_row), 32'(e.row));
        check({e.name, "_col"}, 32'(cursor_col), 32'(e.col));
        check({e.name, "_addr"}, 32'(cursor_addr), 32'(e.row * COLS + e.col));
        if (e.has_word) check({e.name, "_word"}, ram[e.widx], e.wval);
      end
    end
  end

  // Offer one character (inputs change at negedges only); returns at the
  // negedge after the accepting edge.
  task automatic send(input logic [7:0] ch, input exp_t e);
    int n;
    tif.in_valid = 1'b1;
    tif.in_char  = ch;
    exp_q.push_back(e);
    n = 0;
    while (!tif.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tif.in_ready) begin
      check({e.name, "_accept_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
      tif.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    tif.in_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] ch, input string n);
    int nxt;
    nxt = (cur + 1) % DEPTH;
    send(ch, mk(n, 1'b1, cur, {24'h0, ch}, nxt));
    cur = nxt;
  endtask

  task automatic bs(input string n);
    if (cur > 0) begin
      cur--;
      send(8'h08, mk(n, 1'b1, cur, 32'h20, cur));
    end else begin
      send(8'h08, mk(n, 1'b0, 0, 32'h0, 0));
    end
  endtask

  task automatic lf(input string n);
    int r;
    r   = cur / COLS;
    cur = (r == ROWS - 1) ? 0 : (r + 1) * COLS;
    send(8'h0A, mk(n, 1'b0, 0, 32'h0, cur));
  endtask

  task automatic ff(input string n);
    cur = 0;
    send(8'h0C, mk(n, 1'b0, 0, 32'h0, 0));
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tif.in_ready && cnt < 2000);
  endtask

  task automatic check_all_space(input string n);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 32'h20) bad++;
    check(n, 32'(bad), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog timeout");
  end

  initial begin : stim
    int cnt;
    tif.in_valid = 1'b0;
    tif.in_char  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(tif.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_addr", 32'(cursor_addr), 32'd0);
    check("rst_rowcol", {cursor_row, cursor_col}, 32'd0);
    rst = 1'b0;

    wait_ready(cnt);
    check("sweep_len_reset", 32'(cnt), 32'(DEPTH));
    check_all_space("clear_after_reset");
    check("idle_busy", 32'(busy), 32'd0);

    put("H", "put_H");
    put("I", "put_I");
    cur = 0;
    send(8'h0D, mk("cr", 1'b1, 0, 32'h48, 0));
    bs("bs_at_0");
    send(8'h08, mk("bs_at_0_again", 1'b1, 0, 32'h48, 0));

    // FF with 'Z' held: must not be taken during the sweep.
    ff("ff");
    tif.in_valid = 1'b1;
    tif.in_char  = "Z";
    cnt = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check("ff_busy_len", 32'(cnt), 32'(DEPTH));
    check("ff_ready_after", 32'(tif.in_ready), 32'd1);
    check("ff_cleared_0", ram[0], 32'h20);
    check("ff_cleared_1", ram[1], 32'h20);
    put("Z", "z_after_sweep");

    bs("bs_after_z");
    put("A", "ab_A");
    put("B", "ab_B");
    bs("ab_bs");
    check("ab_keep_A", ram[0], 32'h41);
    send(8'h07, mk("bel_ignored", 1'b1, cur, 32'h20, cur));

    for (int i = 0; i < 40; i++) put("A", "fill_row0");
    check("row0_wrap_addr", 32'(cur), 32'(COLS));
    bs("bs_row1");

    lf("lf_row0");
    for (int i = 0; i < 6; i++) lf("lf_down");
    for (int i = 0; i < COLS; i++) put(8'(8'h21 + i), "fill_last_row");
    check("wrap_home_model", 32'(cur), 32'd0);
    for (int i = 0; i < 7; i++) lf("lf_to_7");
    lf("lf_last_row");

    // Reset 100 cycles into a sweep restarts it.
    put("Q", "pre_ff");
    ff("ff2");
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(tif.in_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_addr", 32'(cursor_addr), 32'd0);
    rst = 1'b0;
    wait_ready(cnt);
    check("sweep_len_midrst", 32'(cnt), 32'(DEPTH));
    check_all_space("clear_after_midrst");
    cur = 0;
    put("K", "post_midrst");

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/text_ram_writer.md
# text_ram_writer

Write side of the VGA text display: accepts a stream of ASCII characters over a valid/ready handshake and maintains the 328-word character array that the VGA sync/pixel path reads to draw text. Owns a cursor (row/column), interprets a small set of control codes, and performs screen-clear sweeps. Sits between the character source (keyboard/UART/control logic) and the `ram` array input of the VGA top.

## Interface
- `COLS`, default 41: characters per row.
- `ROWS`, default 8: rows on screen.
- `DEPTH`, default `COLS*ROWS` (328): number of array words; must equal `COLS*ROWS`.
- `clk` input, 1: system clock, the same `clk` that drives the VGA top.
- `rst` input, 1: reset. One clock; reset is synchronous and active-high.
- `in_valid` input, 1: `in_char` holds a character.
- `in_char` input, 8: ASCII code.
- `in_ready` output, 1: block can accept a character this cycle.
- `busy` output, 1: clear sweep in progress.
- `cursor_row` output, 3: current row, 0..ROWS-1.
- `cursor_col` output, 6: current column, 0..COLS-1.
- `cursor_addr` output, 9: `cursor_row*COLS + cursor_col`.
- `ram` output, `[31:0]` × `[DEPTH-1:0]` unpacked: character array. Bits [7:0] hold the ASCII code. Bits [31:8] are always 0.

## Operation
- FSM states:
  - CLEAR: writes 0x20 to one word per cycle at `clr_addr`, counting 0..DEPTH-1, then goes to IDLE. `in_ready`=0, `busy`=1.
  - IDLE: `in_ready`=1, `busy`=0.
- Reset: enter CLEAR with `clr_addr`=0 and cursor=(0,0). The array words themselves have no reset; their contents are defined only after the sweep completes.
- A character is accepted only when `in_valid && in_ready`. Every accepted code is consumed, including codes that are ignored.
- Printable 0x20–0x7E:
  - Write `{24'h0, in_char}` to `ram[cursor_addr]`, then advance the cursor.
  - Advance: col+1. At col=COLS-1 go to (row+1, 0). At (ROWS-1, COLS-1) wrap to (0, 0).
  - No scrolling.
- 0x08 backspace:
  - If `cursor_addr`>0: move back one position (col 0 goes to the previous row's col COLS-1) and write 0x20 at the new position.
  - At address 0: no-op.
- 0x0A newline: go to (row+1, 0). From the last row, go to (0, 0). No write.
- 0x0D carriage return: go to (row, 0). No write.
- 0x0C form feed: enter CLEAR with `clr_addr`=0 and cursor=(0,0).
- All other codes: ignored, cursor unchanged.
- At most one array word is written per cycle (single write port), so the array can later be mapped to block RAM.
- Reset during CLEAR restarts the sweep from 0. Reset in IDLE discards any accept in that cycle; reset has priority over everything.

## Timing
- Accept to array update: the written word and the new cursor are visible the cycle after the accepting edge (latency 1).
- Throughput: one character per cycle in IDLE.
- A sweep takes exactly DEPTH cycles:
  - After reset deassertion: `in_ready` rises on cycle DEPTH; 0x20 is in every word from then on.
  - After a 0x0C accepted at cycle t: `busy`=1 for cycles t+1..t+DEPTH, and `in_ready`=1 again at t+DEPTH+1.
- `in_valid` held high while `in_ready`=0 is not consumed. The source keeps `in_char` stable until accepted.
- Reset values: `in_ready`=0, `busy`=1, `cursor_row`=0, `cursor_col`=0, `cursor_addr`=0.

## Structure
- Package `vga_text_pkg`:
  - COLS, ROWS, DEPTH, address and row/column widths.
  - ASCII constants: SPACE, BS, LF, CR, FF, PRINT_MIN, PRINT_MAX.
  - `wr_state_t` enum {CLEAR, IDLE}.
- Sub-module `text_cursor`: row/column counter with `advance`, `back`, `newline`, `home_col` and `home` commands, plus the derived `addr` output. `text_ram_writer` instantiates it and keeps the FSM, clear counter and array.

## Test plan
- Reset, then idle → `in_ready`=0 for 328 cycles, then 1. Every `ram[i]` reads 32'h00000020; cursor is (0,0).
- Send 'H','I' back-to-back → `ram[0]`=32'h48 and `ram[1]`=32'h49, one cycle after each accept; cursor ends at (0,2) with `cursor_addr`=2.
- Wrap cases:
  - 41 'A's → cursor (1,0), `ram[40]`=32'h41.
  - Filling to address 327 plus one more char → cursor (0,0).
  - LF on row 7 → cursor (0,0).
- Backspace cases:
  - BS at (0,0) → no change.
  - "AB", BS → cursor (0,1), `ram[1]`=32'h20, `ram[0]`=32'h41.
  - BS at (1,0) → cursor (0,40).
- FF with `in_valid` held high and `in_char`='Z' → `busy` high for 328 cycles and 'Z' not written during the sweep. After the sweep 'Z' is accepted and `ram[0]`=32'h5A.
- Reset asserted at sweep cycle 100 → sweep restarts and `in_ready` returns exactly 328 cycles after reset deasserts. 0x07 accepted in IDLE → no write, cursor unchanged.
